pipelined_adder: RTL
====================

Name: pipelined_adder

Overview:
- Parametrised, pipelined add/subtract unit. It is the multi-bit successor of the team's 4-bit ripple-carry parallel adder.
- The carry chain is split into STAGES equal chunks. One chunk resolves per clock, so WIDTH scales without lengthening the critical path.
- A valid/ready handshake on input and output lets it sit directly in the datapath between producer and consumer blocks, with backpressure.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth = number of carry chunks; 1 <= STAGES <= WIDTH.
- CHUNK, WIDTH/STAGES, derived localparam; bits resolved per stage.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c  input  1  carry-in (add mode only).
- sub  input  1  0: sum = a + b + c; 1: sum = a - b (c ignored).
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry-out (add) / NOT borrow (sub).
- ovf  output  1  two's-complement signed overflow of the operation.

Behaviour:
- Reset (rst_n low, asynchronous): all pipeline valid bits = 0, out_valid = 0, sum = 0, cout = 0, ovf = 0. In-flight beats are discarded, no partial result emerges. in_ready = 1 one cycle after deassertion.
- Operand prep at input: b_eff = sub ? ~b : b; cin_eff = sub ? 1 : c.
- Stage k (0..STAGES-1) adds chunk k of a and b_eff plus the carry registered from stage k-1 (cin_eff for k = 0). It registers chunk sum k and the carry.
- Higher operand chunks travel skewed alongside. Lower sum chunks are delayed so all chunks of a beat align at the output register.
- Latency: a beat accepted at edge N appears on out_valid/sum after edge N+STAGES, i.e. STAGES cycles with no stall.
- Throughput: 1 beat/cycle when out_ready is held high.
- ovf = carry into MSB XOR carry out of MSB, computed in the last stage.
- Handshake, global stall:
  - advance = !out_valid || out_ready; in_ready = advance (combinational).
  - A beat transfers in when in_valid && in_ready.
  - The pipe moves one stage on every cycle where advance = 1. Bubbles (valid = 0) move too.
  - When advance = 0, every stage register, including sum/cout/ovf/out_valid, holds.
- Output stability: while out_valid = 1 and out_ready = 0, sum/cout/ovf must not change.
- Simultaneous accept and emit: a new beat enters stage 0 in the same cycle the final beat leaves. No bubble is inserted.
- in_valid low: bubble enters. out_valid later drops for exactly those cycles.
- Wrap-around: sum is modulo 2^WIDTH. Overflow is reported only through cout/ovf, never saturated.
- STAGES = 1: single registered ripple adder, latency 1, same handshake.
- No X propagation: a, b, c, sub are don't-care when in_valid = 0. Their values must not reach outputs tagged valid.

Decomposition:
- Shared package adder_pkg:
  - MODE_ADD = 1'b0, MODE_SUB = 1'b1 constants.
  - a function returning the signed-overflow bit from MSB operands/result.
- Natural sub-module: chunk_adder. It is a combinational CHUNK-bit ripple adder (a, b, cin -> sum, cout, carry into MSB), instantiated STAGES times via generate. Registers stay in pipelined_adder.

Test Plan (WIDTH=16, STAGES=4 unless noted):
- Add with carry across all chunks: a=16'h0FFF, b=16'h0001, c=0, sub=0 -> 4 cycles later sum=16'h1000, cout=0, ovf=0.
- Full wrap: a=16'hFFFF, b=16'h0000, c=1 -> sum=16'h0000, cout=1, ovf=0. Also a=16'h7FFF, b=16'h0001, c=0 -> sum=16'h8000, cout=0, ovf=1.
- Subtract: a=16'h0005, b=16'h0007, sub=1, c=1 (ignored) -> sum=16'hFFFE, cout=0, ovf=0. Also a=16'h8000, b=16'h0001, sub=1 -> sum=16'h7FFF, cout=1, ovf=1.
- Back-to-back plus backpressure:
  - Drive 8 beats in consecutive cycles (a=i, b=i, c=0). Hold out_ready=0 for 3 cycles mid-stream.
  - Results 2i must appear in order, none lost or duplicated, sum held steady while stalled.
  - in_ready must be 0 exactly in stalled cycles.
- Reset mid-operation: 3 beats in flight, pull rst_n low for 1 cycle between edges. out_valid/sum/cout/ovf go 0 immediately (asynchronous) and no flushed beat ever appears.
- Parameter sweep: WIDTH=8/STAGES=1 and WIDTH=32/STAGES=8 with 1000 random beats, random out_ready. Compare against a golden {cout, sum} = a + b_eff + cin_eff model. Latency must equal STAGES when no stall.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared mode encodings and the signed-overflow helper used around the
// pipelined add/subtract unit.
package adder_pkg;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   // Overflow when both operands share a sign that the result does not.
   function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/pipelined_adder_chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder; one instance resolves one
// pipeline stage's slice of the carry chain.
module chunk_adder #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             cmsb
);

   logic [CHUNK:0] carry;

   assign carry[0] = cin;

   for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
      assign sum[gi]      = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
   end

   assign cout = carry[CHUNK];
   assign cmsb = carry[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: the carry chain is cut into STAGES chunks,
// one chunk per clock, with a globally stalled valid/ready pipeline.
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CHUNK = WIDTH / STAGES;

   if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
      $error("pipelined_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
   end

   logic             advance;
   logic [WIDTH-1:0] a_prep;
   logic [WIDTH-1:0] b_prep;
   logic             cin_prep;

   // Per-stage register state. Stage k holds sum chunks 0..k, the operands
   // (only the chunks above k still matter) and the carry out of chunk k.
   logic [WIDTH-1:0] a_reg    [STAGES];
   logic [WIDTH-1:0] b_reg    [STAGES];
   logic [WIDTH-1:0] s_reg    [STAGES];
   logic             carry_reg[STAGES];
   logic             ovf_reg  [STAGES];
   logic             valid_reg[STAGES];

   logic [WIDTH-1:0] a_next    [STAGES];
   logic [WIDTH-1:0] b_next    [STAGES];
   logic [WIDTH-1:0] s_next    [STAGES];
   logic             carry_next[STAGES];
   logic             ovf_next  [STAGES];
   logic             valid_next[STAGES];

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   // Bubbles carry zeroed data so undriven operands never enter the pipe.
   assign a_prep   = in_valid ? a : '0;
   assign b_prep   = in_valid ? ((sub == MODE_SUB) ? ~b : b) : '0;
   assign cin_prep = in_valid && ((sub == MODE_SUB) || c);

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam logic [WIDTH-1:0] CHUNK_MASK = ((WIDTH'(1) << CHUNK) - WIDTH'(1)) << (gi * CHUNK);

      logic [WIDTH-1:0] a_in;
      logic [WIDTH-1:0] b_in;
      logic [WIDTH-1:0] s_in;
      logic             c_in;
      logic             v_in;
      logic [CHUNK-1:0] chunk_sum;
      logic             chunk_cout;
      logic             chunk_cmsb;

      if (gi == 0) begin : g_first
         assign a_in = a_prep;
         assign b_in = b_prep;
         assign s_in = '0;
         assign c_in = cin_prep;
         assign v_in = in_valid;
      end else begin : g_later
         assign a_in = a_reg[gi-1];
         assign b_in = b_reg[gi-1];
         assign s_in = s_reg[gi-1];
         assign c_in = carry_reg[gi-1];
         assign v_in = valid_reg[gi-1];
      end

      chunk_adder #(
         .CHUNK(CHUNK)
      ) u_chunk (
         .a    (a_in[gi*CHUNK +: CHUNK]),
         .b    (b_in[gi*CHUNK +: CHUNK]),
         .cin  (c_in),
         .sum  (chunk_sum),
         .cout (chunk_cout),
         .cmsb (chunk_cmsb)
      );

      assign a_next[gi]     = a_in;
      assign b_next[gi]     = b_in;
      assign s_next[gi]     = (s_in & ~CHUNK_MASK) | (WIDTH'(chunk_sum) << (gi * CHUNK));
      assign carry_next[gi] = chunk_cout;
      // Only the last stage's value is meaningful: its chunk holds the MSB.
      assign ovf_next[gi]   = chunk_cmsb ^ chunk_cout;
      assign valid_next[gi] = v_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            a_reg[k]     <= '0;
            b_reg[k]     <= '0;
            s_reg[k]     <= '0;
            carry_reg[k] <= 1'b0;
            ovf_reg[k]   <= 1'b0;
            valid_reg[k] <= 1'b0;
         end
      end else if (advance) begin
         for (int k = 0; k < STAGES; k++) begin
            a_reg[k]     <= a_next[k];
            b_reg[k]     <= b_next[k];
            s_reg[k]     <= s_next[k];
            carry_reg[k] <= carry_next[k];
            ovf_reg[k]   <= ovf_next[k];
            valid_reg[k] <= valid_next[k];
         end
      end
   end

   assign out_valid = valid_reg[STAGES-1];
   assign sum       = s_reg[STAGES-1];
   assign cout      = carry_reg[STAGES-1];
   assign ovf       = ovf_reg[STAGES-1];

endmodule
